wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage NPC pipeline, directly downstream of the memory stage. It latches each instruction handed over by MEM and selects the register-file write data from the ALU result, load data or CSR read value. It owns the machine-mode CSR file and trap/return sequencing, which means it generates the pipeline flush and PC redirect. It also provides commit and performance outputs for simulation.

## Interface
Parameters:
- RESET_MTVEC, 64'h0, reset value of mtvec
- RESET_MSTATUS, 64'h0000_000a_0000_1800, reset value of mstatus (MPP=11)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_to_wb_valid  in  1  MEM has an instruction for WB
- wb_allow_in  out  1  WB accepts; constant 1
- wb_valid  out  1  WB register holds a live instruction
- mem_pc / mem_inst  in  64 / 32  PC and instruction word
- mem_rd / mem_rd_wen  in  5 / 1  destination register and its write enable
- mem_ld  in  1  instruction is a load
- mem_ld_data  in  64  load data, aligned and extended; valid in the cycle after handoff
- mem_exe_result  in  64  ALU result / address
- mem_ex / mem_ecode / mem_ex_ret  in  1 / 63 / 1  exception flag, cause code, mret
- mem_csr_re / mem_csr_we / mem_csr_set  in  1 each  CSR read / write / set-mode (OR)
- mem_csr_num / mem_csr_wdata  in  12 / 64  CSR address and operand
- rf_we / rf_waddr / rf_wdata  out  1 / 5 / 64  register-file write port
- wb_rd / wb_rd_wen  out  5 / 1  hazard-detect copy (wb_rd_wen gated by wb_valid)
- clear_pipline  out  1  flush all younger stages
- redirect_pc  out  64  fetch target when clear_pipline=1
- commit / commit_pc / commit_inst  out  1 / 64 / 32  retirement report
- inst_cnt  out  64  retired-instruction counter

## Operation
- Latch: when mem_to_wb_valid=1, all mem_* fields except mem_ld_data are captured. wb_valid <= mem_to_wb_valid every cycle.
- Load data is not latched. mem_ld_data is sampled combinationally while wb_valid=1, because MEM produces it one cycle after the address.
- Write data, in priority order:
  - CSR old value when csr_re=1
  - mem_ld_data when ld=1
  - exe_result otherwise
- rf_we = wb_valid & wb_rd_wen & ~wb_ex & (wb_rd!=0). rf_waddr = wb_rd.
- CSR file holds mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
  - Reads of an unimplemented CSR return 0; writes to one are ignored.
  - Write value is (old|wdata) when csr_set=1, wdata otherwise.
  - Written at the clock edge ending the WB cycle, only if wb_valid & csr_we & ~wb_ex.
  - mepc writes force bits[1:0]=0.
- Trap (wb_valid & wb_ex):
  - mepc <= wb_pc; mcause <= {1'b0, wb_ecode}
  - mstatus.MPIE <= MIE; MIE <= 0; MPP <= 2'b11
  - clear_pipline=1; redirect_pc = {mtvec[63:2], 2'b00}
- Return (wb_valid & wb_ex_ret & ~wb_ex):
  - mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b00
  - clear_pipline=1; redirect_pc = mepc (value before this cycle's update)
- Exception takes precedence over ex_ret and over any CSR write in the same instruction.
- Commit: commit = wb_valid & ~wb_ex, with commit_pc/commit_inst taken from the WB register. inst_cnt += 1 on each commit; wraps at 2^64.

## Timing
- Reset outputs and state:
  - wb_valid=0, clear_pipline=0, rf_we=0, commit=0, inst_cnt=0, redirect_pc=0
  - mtvec=RESET_MTVEC, mstatus=RESET_MSTATUS, mepc=mcause=mscratch=0
- Reset while an instruction is in WB: the instruction is dropped; no rf or CSR write, no commit.
- Latency: one cycle from the handoff edge to the rf write. The register file is updated at the end of the WB cycle.
- clear_pipline is combinational from the WB register and high exactly one cycle per trap or mret. MEM masks mem_to_wb_valid with it, so the following cycle has wb_valid=0.
- CSR read returns the value before any write by the same instruction (read-old semantics).
- Back-to-back CSR instructions: the second sees the first's write, since both the write and the next latch happen on the same edge.
- wb_rd_wen=0 whenever wb_valid=0, so stale registers never stall decode.

## Test plan
- ALU add, rd=x5, exe_result=64'h1234: rf_we=1, waddr=5, wdata=64'h1234 one cycle after handoff; inst_cnt=1.
- Load rd=x6, exe_result=0x8000_0010, mem_ld_data=64'hffff_ffff_ffff_ff80 presented in the WB cycle: wdata equals that value. A write to x0 gives rf_we=0.
- csrrw mtvec, wdata=0x8000_0100, rd=x7; then csrrs mtvec, wdata=0x3, rd=x8:
  - x7 gets the reset mtvec value
  - x8 gets 0x8000_0100
  - final mtvec=0x8000_0103
- ecall at pc=0x8000_0040, ecode=11, MIE=1:
  - clear_pipline=1, redirect_pc=mtvec&~3, mepc=0x8000_0040, mcause=11
  - MIE=0, MPIE=1; commit=0; no rf write
- mret after the trap: redirect_pc=0x8000_0040, MIE=1, MPP=0, commit=1.
- rst asserted while wb_valid=1 with csr_we=1: no CSR change, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: latches the MEM handoff, drives the register-file write port,
// owns the machine-mode CSR file and sequences traps / mret into a flush + redirect.
module wb_stage #(
  parameter logic [63:0] RESET_MTVEC   = 64'h0,
  parameter logic [63:0] RESET_MSTATUS = 64'h0000_000a_0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_to_wb_valid,
  output logic        wb_allow_in,
  output logic        wb_valid,
  input  logic [63:0] mem_pc,
  input  logic [31:0] mem_inst,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rd_wen,
  input  logic        mem_ld,
  input  logic [63:0] mem_ld_data,
  input  logic [63:0] mem_exe_result,
  input  logic        mem_ex,
  input  logic [62:0] mem_ecode,
  input  logic        mem_ex_ret,
  input  logic        mem_csr_re,
  input  logic        mem_csr_we,
  input  logic        mem_csr_set,
  input  logic [11:0] mem_csr_num,
  input  logic [63:0] mem_csr_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [4:0]  wb_rd,
  output logic        wb_rd_wen,
  output logic        clear_pipline,
  output logic [63:0] redirect_pc,
  output logic        commit,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic [63:0] inst_cnt
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam int MIE  = 3;
  localparam int MPIE = 7;

  logic        valid_q;
  logic [63:0] pc_q, exe_result_q, csr_wdata_q;
  logic [31:0] inst_q;
  logic [4:0]  rd_q;
  logic        rd_wen_q, ld_q, ex_q, ex_ret_q, csr_re_q, csr_we_q, csr_set_q;
  logic [62:0] ecode_q;
  logic [11:0] csr_num_q;

  logic [63:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] inst_cnt_q, inst_cnt_d;
  logic [63:0] csr_old, csr_new;
  logic        do_trap, do_ret, do_csr_we;

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= mem_to_wb_valid;
  end

  // NOTE: the payload needs no reset; every consumer is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (mem_to_wb_valid) begin
      pc_q         <= mem_pc;
      inst_q       <= mem_inst;
      rd_q         <= mem_rd;
      rd_wen_q     <= mem_rd_wen;
      ld_q         <= mem_ld;
      exe_result_q <= mem_exe_result;
      ex_q         <= mem_ex;
      ecode_q      <= mem_ecode;
      ex_ret_q     <= mem_ex_ret;
      csr_re_q     <= mem_csr_re;
      csr_we_q     <= mem_csr_we;
      csr_set_q    <= mem_csr_set;
      csr_num_q    <= mem_csr_num;
      csr_wdata_q  <= mem_csr_wdata;
    end
  end

  // NOTE: default first so every path assigns csr_old and no latch is inferred.
  always_comb begin
    csr_old = 64'h0;
    case (csr_num_q)
      CSR_MSTATUS:  csr_old = mstatus_q;
      CSR_MTVEC:    csr_old = mtvec_q;
      CSR_MSCRATCH: csr_old = mscratch_q;
      CSR_MEPC:     csr_old = mepc_q;
      CSR_MCAUSE:   csr_old = mcause_q;
      default:      csr_old = 64'h0;
    endcase
  end

  assign csr_new   = csr_set_q ? (csr_old | csr_wdata_q) : csr_wdata_q;
  assign do_trap   = valid_q & ex_q;
  assign do_ret    = valid_q & ex_ret_q & ~ex_q;
  assign do_csr_we = valid_q & csr_we_q & ~ex_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= RESET_MSTATUS;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 64'h0;
      mepc_q     <= 64'h0;
      mcause_q   <= 64'h0;
    end else if (do_trap) begin
      mepc_q               <= pc_q;
      mcause_q             <= {1'b0, ecode_q};
      mstatus_q[MPIE]      <= mstatus_q[MIE];
      mstatus_q[MIE]       <= 1'b0;
      mstatus_q[12:11]     <= 2'b11;
    end else begin
      if (do_csr_we) begin
        case (csr_num_q)
          CSR_MSTATUS:  mstatus_q  <= csr_new;
          CSR_MTVEC:    mtvec_q    <= csr_new;
          CSR_MSCRATCH: mscratch_q <= csr_new;
          CSR_MEPC:     mepc_q     <= {csr_new[63:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= csr_new;
          default:      ;
        endcase
      end
      // Later assignment wins, so mret's mstatus update overrides a same-instruction write.
      if (do_ret) begin
        mstatus_q[MIE]   <= mstatus_q[MPIE];
        mstatus_q[MPIE]  <= 1'b1;
        mstatus_q[12:11] <= 2'b00;
      end
    end
  end

  assign inst_cnt_d = commit ? inst_cnt_q + 64'd1 : inst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) inst_cnt_q <= 64'h0;
    else     inst_cnt_q <= inst_cnt_d;
  end

  assign wb_allow_in   = 1'b1;
  assign wb_valid      = valid_q;
  assign wb_rd         = rd_q;
  assign wb_rd_wen     = valid_q & rd_wen_q;
  assign rf_we         = valid_q & rd_wen_q & ~ex_q & (rd_q != 5'd0);
  assign rf_waddr      = rd_q;
  assign rf_wdata      = csr_re_q ? csr_old : (ld_q ? mem_ld_data : exe_result_q);
  assign clear_pipline = do_trap | do_ret;
  assign redirect_pc   = do_trap ? {mtvec_q[63:2], 2'b00} : (do_ret ? mepc_q : 64'h0);
  assign commit        = valid_q & ~ex_q;
  assign commit_pc     = pc_q;
  assign commit_inst   = inst_q;
  assign inst_cnt      = inst_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load write-back, CSR read-old/write/set,
// ecall trap, mret return and reset while an instruction sits in WB.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_to_wb_valid;
  logic        wb_allow_in, wb_valid;
  logic [63:0] mem_pc;
  logic [31:0] mem_inst;
  logic [4:0]  mem_rd;
  logic        mem_rd_wen, mem_ld;
  logic [63:0] mem_ld_data, mem_exe_result;
  logic        mem_ex;
  logic [62:0] mem_ecode;
  logic        mem_ex_ret, mem_csr_re, mem_csr_we, mem_csr_set;
  logic [11:0] mem_csr_num;
  logic [63:0] mem_csr_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr, wb_rd;
  logic [63:0] rf_wdata;
  logic        wb_rd_wen, clear_pipline;
  logic [63:0] redirect_pc;
  logic        commit;
  logic [63:0] commit_pc;
  logic [31:0] commit_inst;
  logic [63:0] inst_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_to_wb_valid(mem_to_wb_valid), .wb_allow_in(wb_allow_in), .wb_valid(wb_valid),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
    .mem_ld(mem_ld), .mem_ld_data(mem_ld_data), .mem_exe_result(mem_exe_result),
    .mem_ex(mem_ex), .mem_ecode(mem_ecode), .mem_ex_ret(mem_ex_ret),
    .mem_csr_re(mem_csr_re), .mem_csr_we(mem_csr_we), .mem_csr_set(mem_csr_set),
    .mem_csr_num(mem_csr_num), .mem_csr_wdata(mem_csr_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen),
    .clear_pipline(clear_pipline), .redirect_pc(redirect_pc),
    .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand one instruction to WB; returns #1 after the latching edge (inside the WB cycle).
  task automatic drive(input logic [63:0] pc, input logic [4:0] rd, input logic rd_wen,
                       input logic ld, input logic [63:0] exe, input logic ex,
                       input logic [62:0] ecode, input logic ex_ret, input logic re,
                       input logic we, input logic set, input logic [11:0] num,
                       input logic [63:0] wdata);
    mem_pc = pc; mem_inst = pc[31:0] ^ 32'hA5A5_0013;
    mem_rd = rd; mem_rd_wen = rd_wen; mem_ld = ld; mem_exe_result = exe;
    mem_ex = ex; mem_ecode = ecode; mem_ex_ret = ex_ret;
    mem_csr_re = re; mem_csr_we = we; mem_csr_set = set;
    mem_csr_num = num; mem_csr_wdata = wdata;
    mem_to_wb_valid = 1'b1;
    @(posedge clk); #1;
    mem_to_wb_valid = 1'b0;
  endtask

  task automatic alu(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] exe);
    drive(pc, rd, 1'b1, 1'b0, exe, 1'b0, 63'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0);
  endtask

  // csrrs rd, num, x0 : read-only access
  task automatic csr_read(input logic [11:0] num, input logic [4:0] rd);
    drive(64'h8000_1000, rd, 1'b1, 1'b0, 64'h0, 1'b0, 63'd0, 1'b0, 1'b1, 1'b0, 1'b1, num, 64'h0);
  endtask

  task automatic csr_rw(input logic [11:0] num, input logic [4:0] rd, input logic set,
                        input logic [63:0] wdata);
    drive(64'h8000_2000, rd, 1'b1, 1'b0, 64'h0, 1'b0, 63'd0, 1'b0, 1'b1, 1'b1, set, num, wdata);
  endtask

  task automatic idle;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_to_wb_valid = 1'b0; mem_ld_data = 64'h0;
    mem_pc = '0; mem_inst = '0; mem_rd = '0; mem_rd_wen = 1'b0; mem_ld = 1'b0;
    mem_exe_result = '0; mem_ex = 1'b0; mem_ecode = '0; mem_ex_ret = 1'b0;
    mem_csr_re = 1'b0; mem_csr_we = 1'b0; mem_csr_set = 1'b0; mem_csr_num = '0; mem_csr_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_clear", {63'd0, clear_pipline}, 64'd0);
    check("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check("rst_commit", {63'd0, commit}, 64'd0);
    check("rst_inst_cnt", inst_cnt, 64'd0);
    check("rst_redirect", redirect_pc, 64'd0);
    check("rst_rd_wen", {63'd0, wb_rd_wen}, 64'd0);
    check("allow_in", {63'd0, wb_allow_in}, 64'd1);

    // ALU add x5
    alu(64'h8000_0000, 5'd5, 64'h1234);
    check("alu_rf_we", {63'd0, rf_we}, 64'd1);
    check("alu_waddr", {59'd0, rf_waddr}, 64'd5);
    check("alu_wdata", rf_wdata, 64'h1234);
    check("alu_commit", {63'd0, commit}, 64'd1);
    check("alu_commit_pc", commit_pc, 64'h8000_0000);
    check("alu_commit_inst", {32'd0, commit_inst}, {32'd0, 32'h25A5_0013});
    check("alu_rd_wen", {63'd0, wb_rd_wen}, 64'd1);
    idle;
    check("alu_inst_cnt", inst_cnt, 64'd1);
    check("idle_valid", {63'd0, wb_valid}, 64'd0);
    check("idle_rd_wen", {63'd0, wb_rd_wen}, 64'd0);
    check("idle_rf_we", {63'd0, rf_we}, 64'd0);

    // Load x6: data arrives during the WB cycle
    drive(64'h8000_0004, 5'd6, 1'b1, 1'b1, 64'h8000_0010, 1'b0, 63'd0, 1'b0,
          1'b0, 1'b0, 1'b0, 12'h0, 64'h0);
    mem_ld_data = 64'hffff_ffff_ffff_ff80;
    #1;
    check("ld_rf_we", {63'd0, rf_we}, 64'd1);
    check("ld_waddr", {59'd0, rf_waddr}, 64'd6);
    check("ld_wdata", rf_wdata, 64'hffff_ffff_ffff_ff80);

    // Write to x0 is suppressed but still commits
    alu(64'h8000_0008, 5'd0, 64'h77);
    check("x0_rf_we", {63'd0, rf_we}, 64'd0);
    check("x0_commit", {63'd0, commit}, 64'd1);
    idle;
    check("x0_inst_cnt", inst_cnt, 64'd3);

    // csrrw / csrrs mtvec back-to-back, then read back
    csr_rw(12'h305, 5'd7, 1'b0, 64'h8000_0100);
    check("csrrw_old", rf_wdata, 64'h0);
    check("csrrw_waddr", {59'd0, rf_waddr}, 64'd7);
    csr_rw(12'h305, 5'd8, 1'b1, 64'h3);
    check("csrrs_old", rf_wdata, 64'h8000_0100);
    csr_read(12'h305, 5'd9);
    check("mtvec_final", rf_wdata, 64'h8000_0103);

    // Unimplemented CSR: write ignored, reads zero
    csr_rw(12'h7c0, 5'd10, 1'b0, 64'h5);
    check("unimpl_old", rf_wdata, 64'h0);
    csr_read(12'h7c0, 5'd11);
    check("unimpl_read", rf_wdata, 64'h0);

    // Set MIE
    csr_rw(12'h300, 5'd12, 1'b0, 64'h0000_000a_0000_1808);
    check("mstatus_reset", rf_wdata, 64'h0000_000a_0000_1800);

    // ecall, also carrying a mscratch write that must be suppressed
    drive(64'h8000_0040, 5'd1, 1'b1, 1'b0, 64'h99, 1'b1, 63'd11, 1'b0,
          1'b0, 1'b1, 1'b0, 12'h340, 64'hdead);
    check("trap_clear", {63'd0, clear_pipline}, 64'd1);
    check("trap_redirect", redirect_pc, 64'h8000_0100);
    check("trap_commit", {63'd0, commit}, 64'd0);
    check("trap_rf_we", {63'd0, rf_we}, 64'd0);
    idle;
    check("trap_clear_after", {63'd0, clear_pipline}, 64'd0);
    csr_read(12'h341, 5'd13);
    check("trap_mepc", rf_wdata, 64'h8000_0040);
    csr_read(12'h342, 5'd13);
    check("trap_mcause", rf_wdata, 64'd11);
    csr_read(12'h300, 5'd13);
    check("trap_mstatus", rf_wdata, 64'h0000_000a_0000_1880);
    csr_read(12'h340, 5'd13);
    check("trap_mscratch", rf_wdata, 64'h0);

    // mret
    drive(64'h8000_0100, 5'd0, 1'b0, 1'b0, 64'h0, 1'b0, 63'd0, 1'b1,
          1'b0, 1'b0, 1'b0, 12'h0, 64'h0);
    check("mret_clear", {63'd0, clear_pipline}, 64'd1);
    check("mret_redirect", redirect_pc, 64'h8000_0040);
    check("mret_commit", {63'd0, commit}, 64'd1);
    idle;
    csr_read(12'h300, 5'd14);
    check("mret_mstatus", rf_wdata, 64'h0000_000a_0000_0088);

    // mepc low bits forced to zero
    csr_rw(12'h341, 5'd15, 1'b0, 64'h8000_0047);
    check("mepc_old", rf_wdata, 64'h8000_0040);
    csr_read(12'h341, 5'd15);
    check("mepc_align", rf_wdata, 64'h8000_0044);
    idle;
    check("cnt_total", inst_cnt, 64'd17);

    // Reset while a CSR write sits in WB
    csr_rw(12'h305, 5'd16, 1'b0, 64'h55);
    check("pre_rst_valid", {63'd0, wb_valid}, 64'd1);
    rst = 1'b1;
    idle;
    rst = 1'b0;
    check("rstwb_valid", {63'd0, wb_valid}, 64'd0);
    check("rstwb_rf_we", {63'd0, rf_we}, 64'd0);
    check("rstwb_commit", {63'd0, commit}, 64'd0);
    check("rstwb_clear", {63'd0, clear_pipline}, 64'd0);
    check("rstwb_cnt", inst_cnt, 64'd0);
    csr_read(12'h305, 5'd17);
    check("rstwb_mtvec", rf_wdata, 64'h0);
    csr_read(12'h300, 5'd17);
    check("rstwb_mstatus", rf_wdata, 64'h0000_000a_0000_1800);
    idle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
